vga_pixel_sink: RTL and testbench
=================================

Name: vga_pixel_sink

Overview:
- Receiving end of the game's pixel-write interface (VGA_X, VGA_Y, VGA_COLOR, plot) driven by the display logic.
- Stores each plotted pixel in a 160x120x3-bit frame buffer.
- Scans the buffer out continuously as 640x480@60 VGA, with each stored pixel replicated as a 4x4 block.
- Sits between the display/game logic and the DE-series VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front porch pixels
- H_SYNC, 96, hsync pulse pixels
- H_BACK, 48, back porch pixels
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, back porch lines

Ports:
- CLOCK_50  in  1  50 MHz system clock
- resetn  in  1  asynchronous active-low reset
- VGA_X  in  8  write x coordinate, 0..159
- VGA_Y  in  7  write y coordinate, 0..119
- VGA_COLOR  in  3  write colour {R,G,B}
- plot  in  1  write strobe, one write per cycle high
- VGA_R  out  8  red DAC value
- VGA_G  out  8  green DAC value
- VGA_B  out  8  blue DAC value
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during visible region
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  25 MHz pixel clock
- frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Clock and reset: one clock, CLOCK_50; resetn is asynchronous, active-low.
- Reset values:
  - pix_en = 0; h_cnt = 0; v_cnt = 0; VGA_CLK = 0.
  - VGA_R/G/B = 0; VGA_HS = 1; VGA_VS = 1; VGA_BLANK_N = 0; frame_start = 0.
  - Pipeline registers: the same idle values.
- Frame buffer:
  - Contents power up to 0 and are NOT cleared by resetn.
  - Reset mid-frame aborts the scan only; stored pixels survive.
- Write port:
  - Address = VGA_Y*160 + VGA_X, computed as (Y<<7)+(Y<<5)+X, 15 bits.
  - Write occurs on a rising edge where plot=1, VGA_X<160 and VGA_Y<120.
  - Out-of-range coordinates are silently dropped, with no aliasing.
  - Writes are accepted every cycle, independent of scan position or pix_en.
  - Writes are accepted while resetn is high.
- Pixel enable:
  - pix_en toggles every clock.
  - VGA_CLK is the registered copy of pix_en (25 MHz).
- Scan counters:
  - Advance only on cycles with pix_en=1.
  - h_cnt counts 0..799, then wraps to 0 and increments v_cnt.
  - v_cnt counts 0..524, then wraps to 0.
- Read address: (v_cnt>>2)*160 + (h_cnt>>2), computed only when h_cnt<640 and v_cnt<480; otherwise don't-care.
- Read timing: synchronous, 1 clock.
- Output registration, on the clock after read data returns:
  - Total latency from counter value to pins is 2 clocks.
  - hsync, vsync, blank and frame_start are delayed through matching 2-stage pipes so all outputs stay aligned.
- Colour out:
  - Bit 2 → VGA_R = 8'hFF else 8'h00.
  - Bit 1 → VGA_G, bit 0 → VGA_B, same mapping.
  - Outside the active region all three are forced to 0.
- Sync generation (pre-pipeline):
  - hs = 0 iff 656 ≤ h_cnt ≤ 751.
  - vs = 0 iff 490 ≤ v_cnt ≤ 491.
  - blank_n = 1 iff h_cnt<640 and v_cnt<480.
- frame_start: 1 for exactly one clock when (h_cnt,v_cnt)=(0,0) and pix_en=1, after the 2-clock pipe.
- Simultaneous write and scan read of the same address: the read returns the old data (read-before-write); the new value appears on the next frame.
- Sequencing: no stalls and no backpressure. The block has no state machine beyond the counters and pipes.

Test Plan:
- Reset: hold resetn=0 for 10 clocks, then release.
  - During reset: HS=VS=1, BLANK_N=0, RGB=0.
  - First frame_start comes 2 clocks after the first pix_en=1 cycle.
- Timing: run 2 full frames.
  - HS low for 96 pixel ticks (192 clocks) every 800 ticks.
  - VS low for 2 lines every 525 lines.
  - frame_start period = 840000 clocks.
- Single write: plot X=5, Y=3, COLOR=3'b100.
  - Screen pixels x=20..23, lines 12..15 show R=FF, G=B=00.
  - Neighbouring pixels x=19 and x=24 stay 0.
- Range check: plot at X=160, Y=0 and at X=0, Y=120, both colour 7.
  - No visible change anywhere, in particular at (0,0) and (0,119).
- Collision: write X=0, Y=0, COLOR=7 on the exact cycle the scan reads address 0.
  - That frame shows the old value 0.
  - The next frame shows white (all FF).
- Mid-frame reset: fill the buffer with colour 2, then pulse resetn low at v_cnt=200.
  - Scan restarts at (0,0).
  - The first frame after reset still shows G=FF over the whole active area.

Source files
------------

// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_sink
//  Purpose  : Pixel-write sink for the game display. Stores plotted pixels in
//             a 160x120x3-bit frame buffer and scans it out as VGA with every
//             stored pixel replicated into a 4x4 screen block.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_sink #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] VGA_X,
    input  logic [6:0] VGA_Y,
    input  logic [2:0] VGA_COLOR,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_start
);

    localparam int c_h_total  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_hw       = $clog2(c_h_total);
    localparam int c_vw       = $clog2(c_v_total);
    localparam int c_fb_depth = 160 * 120;

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_first   = c_hw'(H_ACTIVE + H_FRONT);
    localparam logic [c_hw-1:0] c_hs_last    = c_hw'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_first   = c_vw'(V_ACTIVE + V_FRONT);
    localparam logic [c_vw-1:0] c_vs_last    = c_vw'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [7:0]      c_x_lim      = 8'd160;
    localparam logic [6:0]      c_y_lim      = 7'd120;

    // Scan state
    logic            r_pix_en;
    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;

    // Stage-0 decode of the current scan position
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic        w_fs;
    logic [14:0] w_rd_row;
    logic [14:0] w_rd_addr;

    // Write port decode
    logic        w_wr_en;
    logic [14:0] w_wr_row;
    logic [14:0] w_wr_addr;

    // Frame buffer and stage-1 pipe
    logic [2:0]  r_fb [0:c_fb_depth-1];
    logic [2:0]  r_rd_data;
    logic        r_hs_d1;
    logic        r_vs_d1;
    logic        r_blank_n_d1;
    logic        r_fs_d1;

    assign VGA_SYNC_N = 1'b0;

    // Pixel-rate enable, VGA clock copy and the horizontal/vertical scan counters
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pix_en <= 1'b0;
            VGA_CLK  <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            VGA_CLK  <= r_pix_en;
            if (r_pix_en) begin
                if (r_h_cnt == c_h_last) begin
                    r_h_cnt <= '0;
                    if (r_v_cnt == c_v_last) begin
                        r_v_cnt <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 1'b1;
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    // Sync/blank decode and read address; the address only matters while visible
    always_comb begin
        w_active  = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
        w_hs      = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
        w_vs      = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));
        w_fs      = (r_h_cnt == '0) && (r_v_cnt == '0) && r_pix_en;
        w_rd_row  = 15'(r_v_cnt[c_vw-1:2]);
        w_rd_addr = '0;
        if (w_active) begin
            w_rd_addr = (w_rd_row << 7) + (w_rd_row << 5) + 15'(r_h_cnt[c_hw-1:2]);
        end
    end

    // Write decode: Y*160+X via shifts; out-of-range coordinates never write
    always_comb begin
        w_wr_row  = 15'(VGA_Y);
        w_wr_addr = (w_wr_row << 7) + (w_wr_row << 5) + 15'(VGA_X);
        w_wr_en   = plot && resetn && (VGA_X < c_x_lim) && (VGA_Y < c_y_lim);
    end

    // Frame buffer write port; contents deliberately survive resetn
    always_ff @(posedge CLOCK_50) begin
        if (w_wr_en) begin
            r_fb[w_wr_addr] <= VGA_COLOR;
        end
    end

    // Stage 1: synchronous read (old data on a same-cycle write) plus matching control delay
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_rd_data    <= 3'b000;
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_blank_n_d1 <= 1'b0;
            r_fs_d1      <= 1'b0;
        end else begin
            r_rd_data    <= r_fb[w_rd_addr];
            r_hs_d1      <= w_hs;
            r_vs_d1      <= w_vs;
            r_blank_n_d1 <= w_active;
            r_fs_d1      <= w_fs;
        end
    end

    // Stage 2: expand colour bits to full-scale DAC values, black outside the visible area
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            VGA_R       <= (r_blank_n_d1 && r_rd_data[2]) ? 8'hFF : 8'h00;
            VGA_G       <= (r_blank_n_d1 && r_rd_data[1]) ? 8'hFF : 8'h00;
            VGA_B       <= (r_blank_n_d1 && r_rd_data[0]) ? 8'hFF : 8'h00;
            VGA_HS      <= r_hs_d1;
            VGA_VS      <= r_vs_d1;
            VGA_BLANK_N <= r_blank_n_d1;
            frame_start <= r_fs_d1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pixel_sink
//  Purpose  : Self-checking bench for vga_pixel_sink on a shrunken raster so
//             that several complete frames fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_sink;

    localparam int HA = 64;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 2;
    localparam int VA = 20;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;          // pixel ticks per frame
    localparam int VIS_COLS = HA / 4;     // buffer columns that reach the screen
    localparam int VIS_ROWS = VA / 4;     // buffer rows that reach the screen

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic       vclk;
        logic       sync_n;
    } pins_t;

    typedef struct {
        int         ed;
        int         addr;
        logic [2:0] col;
    } wr_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vx    = 8'd0;
    logic [6:0] vy    = 7'd0;
    logic [2:0] vc    = 3'd0;
    logic       plot  = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

    int cyc     = 0;   // posedges since the last reset release
    int abs_cyc = 0;   // posedges since time zero
    int n_cmp   = 0;
    int n_bad   = 0;

    logic [2:0] fb [0:19199];
    wr_t        wq [$];

    vga_pixel_sink #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (rst_n),
        .VGA_X      (vx),
        .VGA_Y      (vy),
        .VGA_COLOR  (vc),
        .plot       (plot),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_CLK    (VGA_CLK),
        .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) abs_cyc <= abs_cyc + 1;

    // A write landing on edge E is seen by reads on edges after E, i.e. by pins two edges later.
    function automatic void commit_writes();
        while (wq.size() > 0 && wq[0].ed <= abs_cyc - 2) begin
            fb[wq[0].addr] = wq[0].col;
            void'(wq.pop_front());
        end
    endfunction

    // Expected pins after the c-th edge since reset: pins show the raster position two clocks back.
    function automatic pins_t model(int c);
        pins_t      e;
        int         n, h, v;
        logic [2:0] col;
        e = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bl: 1'b0,
              fs: 1'b0, vclk: 1'b0, sync_n: 1'b0};
        e.vclk = (c >= 1) && (c % 2 == 0);
        if (c >= 2) begin
            n    = (c - 2) / 2;
            h    = n % HT;
            v    = (n / HT) % VT;
            e.hs = !(h >= HA + HF && h < HA + HF + HS);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            e.bl = (h < HA) && (v < VA);
            e.fs = (n % FT == 0) && ((c - 2) % 2 == 1);
            if (e.bl) begin
                col = fb[(v / 4) * 160 + h / 4];
                e.r = col[2] ? 8'hFF : 8'h00;
                e.g = col[1] ? 8'hFF : 8'h00;
                e.b = col[0] ? 8'hFF : 8'h00;
            end
        end
        return e;
    endfunction

    function automatic pins_t sample();
        pins_t o;
        o = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK, VGA_SYNC_N};
        return o;
    endfunction

    // Raster position (h, v) the pins currently display, from the edge count
    function automatic int pin_h(int c);
        return ((c - 2) / 2) % HT;
    endfunction

    function automatic int pin_v(int c);
        return (((c - 2) / 2) / HT) % VT;
    endfunction

    task automatic wr_pixel(input int x, input int y, input logic [2:0] col);
        @(negedge clk);
        vx   = x[7:0];
        vy   = y[6:0];
        vc   = col;
        plot = 1'b1;
        if (x < 160 && y < 120) wq.push_back('{ed: abs_cyc + 1, addr: y * 160 + x, col: col});
    endtask

    task automatic end_writes();
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic fill_visible(input logic [2:0] col);
        for (int y = 0; y < VIS_ROWS; y++)
            for (int x = 0; x < VIS_COLS; x++)
                wr_pixel(x, y, col);
        end_writes();
    endtask

    task automatic test_reset();
        pins_t obs, exp;
        int    first_fs;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, frame_start, VGA_CLK} !==
                {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_idle i=%0d act hs=%b vs=%b bl=%b rgb=%h%h%h fs=%b clk=%b req hs=1 vs=1 bl=0 rgb=0 fs=0 clk=0",
                         i, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, frame_start, VGA_CLK);
            end
        end
        rst_n    = 1'b1;
        first_fs = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_exit c=%0d act=%h req=%h", cyc, obs, exp);
            end
            if (obs.fs && first_fs < 0) first_fs = cyc;
        end
        n_cmp++;
        if (first_fs !== 3) begin
            n_bad++;
            $display("FAIL first_frame_start act_cycle=%0d req_cycle=3", first_fs);
        end
    endtask

    task automatic test_timing();
        pins_t obs, exp;
        int    hs_run, vs_run, last_fs, periods;
        hs_run = 0; vs_run = 0; last_fs = -1; periods = 0;
        for (int i = 0; i < 6 * FT + 100; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL timing_pins c=%0d act=%h req=%h", cyc, obs, exp);
            end
            if (!obs.hs) hs_run++;
            else if (hs_run > 0) begin
                n_cmp++;
                if (hs_run !== 2 * HS) begin
                    n_bad++;
                    $display("FAIL hs_width act=%0d req=%0d clocks", hs_run, 2 * HS);
                end
                hs_run = 0;
            end
            if (!obs.vs) vs_run++;
            else if (vs_run > 0) begin
                n_cmp++;
                if (vs_run !== 2 * VS * HT) begin
                    n_bad++;
                    $display("FAIL vs_width act=%0d req=%0d clocks", vs_run, 2 * VS * HT);
                end
                vs_run = 0;
            end
            if (obs.fs) begin
                if (last_fs >= 0) begin
                    periods++;
                    n_cmp++;
                    if (cyc - last_fs !== 2 * FT) begin
                        n_bad++;
                        $display("FAIL frame_period act=%0d req=%0d clocks", cyc - last_fs, 2 * FT);
                    end
                end
                last_fs = cyc;
            end
        end
        n_cmp++;
        if (periods < 2) begin
            n_bad++;
            $display("FAIL frame_count act=%0d req>=2 frame periods", periods);
        end
    endtask

    task automatic test_random_pattern();
        pins_t obs, exp;
        for (int y = 0; y < VIS_ROWS; y++)
            for (int x = 0; x < VIS_COLS; x++)
                wr_pixel(x, y, 3'($urandom_range(7, 0)));
        for (int i = 0; i < 40; i++)
            wr_pixel(int'($urandom_range(175, 0)), int'($urandom_range(127, 0)), 3'($urandom_range(7, 0)));
        end_writes();
        for (int i = 0; i < 2 * FT + 20; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL random_frame c=%0d act=%h req=%h", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_single_write();
        pins_t      obs, exp;
        int         h, v;
        logic [7:0] req_r;
        fill_visible(3'b000);
        wr_pixel(5, 3, 3'b100);
        end_writes();
        for (int i = 0; i < 2 * FT + 20; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_frame c=%0d act=%h req=%h", cyc, obs, exp);
            end
            h = pin_h(cyc);
            v = pin_v(cyc);
            if (i > 8 && (v == 12 || v == 15) && (h == 19 || h == 20 || h == 23 || h == 24)) begin
                req_r = (h == 20 || h == 23) ? 8'hFF : 8'h00;
                n_cmp++;
                if ({VGA_R, VGA_G, VGA_B} !== {req_r, 16'h0000}) begin
                    n_bad++;
                    $display("FAIL single_pixel x=%0d y=%0d act=%h%h%h req=%h0000", h, v, VGA_R, VGA_G, VGA_B, req_r);
                end
            end
        end
    endtask

    task automatic test_range();
        pins_t obs, exp;
        int    h, v;
        wr_pixel(160, 0, 3'b111);
        wr_pixel(0, 120, 3'b111);
        end_writes();
        for (int i = 0; i < 2 * FT + 20; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL range_frame c=%0d act=%h req=%h", cyc, obs, exp);
            end
            h = pin_h(cyc);
            v = pin_v(cyc);
            if (i > 8 && h == 0 && (v == 0 || v == 4)) begin
                n_cmp++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
                    n_bad++;
                    $display("FAIL range_drop x=0 y=%0d act=%h%h%h req=000000", v, VGA_R, VGA_G, VGA_B);
                end
            end
        end
    endtask

    task automatic test_collision();
        pins_t obs, exp;
        int    target;
        target = ((cyc + 4) / (2 * FT) + 1) * (2 * FT);
        while (cyc < target + 2 * FT + 20) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL collision_frame c=%0d act=%h req=%h", cyc, obs, exp);
            end
            if (cyc == target + 2) begin
                n_cmp++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
                    n_bad++;
                    $display("FAIL collision_old act=%h%h%h req=000000", VGA_R, VGA_G, VGA_B);
                end
            end
            if (cyc == target + 2 * FT + 2) begin
                n_cmp++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
                    n_bad++;
                    $display("FAIL collision_new act=%h%h%h req=FFFFFF", VGA_R, VGA_G, VGA_B);
                end
            end
            if (cyc == target) begin
                vx = 8'd0; vy = 7'd0; vc = 3'b111; plot = 1'b1;
                wq.push_back('{ed: abs_cyc + 1, addr: 0, col: 3'b111});
            end else begin
                plot = 1'b0;
            end
        end
        plot = 1'b0;
    endtask

    task automatic test_midframe_reset();
        pins_t obs, exp;
        int    guard, first_fs, h, v;
        fill_visible(3'b010);
        guard = 0;
        while (((cyc / 2) / HT) % VT != 10 && guard < 4 * FT) begin
            @(negedge clk);
            commit_writes();
            guard++;
        end
        n_cmp++;
        if (guard >= 4 * FT) begin
            n_bad++;
            $display("FAIL midreset_wait act=timeout req=line 10 reached");
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = sample();
            exp = model(0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midreset_idle act=%h req=%h", obs, exp);
            end
        end
        rst_n    = 1'b1;
        first_fs = -1;
        for (int i = 0; i < 2 * FT + 20; i++) begin
            @(negedge clk);
            commit_writes();
            obs = sample();
            exp = model(cyc);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midreset_frame c=%0d act=%h req=%h", cyc, obs, exp);
            end
            if (obs.fs && first_fs < 0) first_fs = cyc;
            h = pin_h(cyc);
            v = pin_v(cyc);
            if (cyc >= 2 && cyc < 2 * FT + 2 && h < HA && v < VA && (h % 7 == 0)) begin
                n_cmp++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'h00FF00) begin
                    n_bad++;
                    $display("FAIL midreset_green x=%0d y=%0d act=%h%h%h req=00FF00", h, v, VGA_R, VGA_G, VGA_B);
                end
            end
        end
        n_cmp++;
        if (first_fs !== 3) begin
            n_bad++;
            $display("FAIL midreset_restart act_cycle=%0d req_cycle=3", first_fs);
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) fb[i] = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fill_visible(3'b000);
        test_reset();
        test_timing();
        test_random_pattern();
        test_single_write();
        test_range();
        test_collision();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
